// File: rtl/uart_hex_tx.sv
// Prints one byte as two uppercase ASCII hex characters (optionally followed by CR LF)
// over an 8N1 UART line. Characters go back to back with no inter-frame gap.
//
// state | meaning
// IDLE  | line high, rdy=1, waiting for start
// START | start bit (0) of the current character
// DATA  | eight data bits, LSB first
// STOP  | stop bit (1); then next character or back to IDLE
module uart_hex_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CRLF         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       rdy,
    output logic       done
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    IDX_LAST = (CRLF != 0) ? 2'd3 : 2'd1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [1:0]    r_idx;
    logic [7:0]    r_byte;
    logic [7:0]    w_char;
    logic          w_bit_end;
    logic          w_last_char;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] n8;
        n8 = {4'h0, n};
        return (n < 4'd10) ? (8'h30 + n8) : (8'h37 + n8);
    endfunction

    assign w_bit_end   = (r_cnt == CNT_LAST);
    assign w_last_char = (r_idx == IDX_LAST);

    always_comb begin
        w_char = 8'h0A;
        case (r_idx)
            2'd0:    w_char = hex_char(r_byte[7:4]);
            2'd1:    w_char = hex_char(r_byte[3:0]);
            2'd2:    w_char = 8'h0D;
            default: w_char = 8'h0A;
        endcase
    end

    always_comb begin
        w_next = r_state;
        tx     = 1'b1;
        rdy    = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                rdy = 1'b1;
                if (start) w_next = START;
            end
            START: begin
                tx = 1'b0;
                if (w_bit_end) w_next = DATA;
            end
            DATA: begin
                tx = w_char[r_bit];
                if (w_bit_end && (r_bit == 3'd7)) w_next = STOP;
            end
            STOP: begin
                tx   = 1'b1;
                done = w_bit_end && w_last_char;
                if (w_bit_end) w_next = w_last_char ? IDLE : START;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_idx   <= 2'd0;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_cnt <= '0;
                r_bit <= 3'd0;
                r_idx <= 2'd0;
                if (start) r_byte <= din;
            end else begin
                // bit counter wraps 7 -> 0 on its own as DATA hands over to STOP
                r_cnt <= w_bit_end ? '0 : (r_cnt + 1'b1);
                if ((r_state == DATA) && w_bit_end) r_bit <= r_bit + 3'd1;
                if ((r_state == STOP) && w_bit_end) r_idx <= w_last_char ? 2'd0 : (r_idx + 2'd1);
            end
        end
    end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Bench for uart_hex_tx: two instances (CRLF=1 and CRLF=0) at 4 clocks per bit, checked every
// cycle against a message-position model, plus a line decoder pinned with literal frames.
module tb_uart_hex_tx;

    localparam int CPB  = 4;
    localparam int LEN1 = 4 * 10 * CPB;
    localparam int LEN2 = 2 * 10 * CPB;

    logic       clk;
    logic       rst;
    logic       start1, start2;
    logic [7:0] din1, din2;
    logic       tx1, rdy1, done1;
    logic       tx2, rdy2, done2;

    int checks = 0;
    int errors = 0;

    uart_hex_tx #(.CLKS_PER_BIT(CPB), .CRLF(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .din(din1),
        .tx(tx1), .rdy(rdy1), .done(done1)
    );

    uart_hex_tx #(.CLKS_PER_BIT(CPB), .CRLF(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .din(din2),
        .tx(tx2), .rdy(rdy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        int v;
        v = int'(n);
        return 8'((v < 10) ? (48 + v) : (65 + v - 10));
    endfunction

    // Line level at position p of the message for byte d: 10 bits of CPB cycles per character.
    function automatic logic exp_level(input logic [7:0] d, input int p);
        int         ci, bp;
        logic [7:0] c;
        ci = p / (10 * CPB);
        bp = (p % (10 * CPB)) / CPB;
        case (ci)
            0:       c = hexc(d[7:4]);
            1:       c = hexc(d[3:0]);
            2:       c = 8'h0D;
            default: c = 8'h0A;
        endcase
        if (bp == 0) return 1'b0;
        if (bp == 9) return 1'b1;
        return c[bp-1];
    endfunction

    // Reference model: a message is just a position running from 0 to LEN-1.
    bit         m1_busy, m2_busy;
    int         m1_pos, m2_pos;
    logic [7:0] m1_byte, m2_byte;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m1_busy <= 1'b0; m1_pos <= 0; m1_byte <= 8'h00;
        end else if (m1_busy) begin
            if (m1_pos == LEN1 - 1) m1_busy <= 1'b0;
            m1_pos <= m1_pos + 1;
        end else if (start1) begin
            m1_busy <= 1'b1; m1_pos <= 0; m1_byte <= din1;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m2_busy <= 1'b0; m2_pos <= 0; m2_byte <= 8'h00;
        end else if (m2_busy) begin
            if (m2_pos == LEN2 - 1) m2_busy <= 1'b0;
            m2_pos <= m2_pos + 1;
        end else if (start2) begin
            m2_busy <= 1'b1; m2_pos <= 0; m2_byte <= din2;
        end
    end

    always @(negedge clk) begin
        check("tx1",   tx1,   m1_busy ? exp_level(m1_byte, m1_pos) : 1'b1);
        check("rdy1",  rdy1,  !m1_busy);
        check("done1", done1, m1_busy && (m1_pos == LEN1 - 1));
        check("tx2",   tx2,   m2_busy ? exp_level(m2_byte, m2_pos) : 1'b1);
        check("rdy2",  rdy2,  !m2_busy);
        check("done2", done2, m2_busy && (m2_pos == LEN2 - 1));
    end

    // Line decoders sampling each bit at its centre.
    logic [7:0] dec1[$];
    logic [7:0] dec2[$];
    bit         d1_busy, d2_busy;
    int         d1_cnt, d2_cnt;
    logic [7:0] d1_sh, d2_sh;

    always @(negedge clk or negedge rst) begin
        int bi;
        if (!rst) begin
            d1_busy = 1'b0;
        end else if (!d1_busy) begin
            if (tx1 == 1'b0) begin d1_busy = 1'b1; d1_cnt = 0; end
        end else begin
            d1_cnt++;
            if (d1_cnt % CPB == CPB / 2) begin
                bi = d1_cnt / CPB;
                if (bi >= 1 && bi <= 8) d1_sh[bi-1] = tx1;
                else if (bi == 9) begin
                    check("stop_bit1", tx1, 1);
                    dec1.push_back(d1_sh);
                end
            end
            if (d1_cnt == 10 * CPB - 1) d1_busy = 1'b0;
        end
    end

    always @(negedge clk or negedge rst) begin
        int bi;
        if (!rst) begin
            d2_busy = 1'b0;
        end else if (!d2_busy) begin
            if (tx2 == 1'b0) begin d2_busy = 1'b1; d2_cnt = 0; end
        end else begin
            d2_cnt++;
            if (d2_cnt % CPB == CPB / 2) begin
                bi = d2_cnt / CPB;
                if (bi >= 1 && bi <= 8) d2_sh[bi-1] = tx2;
                else if (bi == 9) begin
                    check("stop_bit2", tx2, 1);
                    dec2.push_back(d2_sh);
                end
            end
            if (d2_cnt == 10 * CPB - 1) d2_busy = 1'b0;
        end
    end

    // Every low stretch on the line must span whole bit times.
    int   run1;
    logic prev1;
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            run1  = 0;
            prev1 = 1'b1;
        end else if (tx1 == prev1) begin
            run1++;
        end else begin
            if (prev1 == 1'b0) check("low_run_mult", run1 % CPB, 0);
            run1  = 1;
            prev1 = tx1;
        end
    end

    task automatic drive(input int which, input logic s, input logic [7:0] d);
        if (which == 1) begin start1 = s; din1 = d; end
        else            begin start2 = s; din2 = d; end
    endtask

    // Called at a negedge; returns at the negedge where done is high.
    task automatic send(input int which, input logic [7:0] d, input int inject_at, output int span);
        int k;
        bit rdy_seen;
        k = 0;
        while (((which == 1) ? rdy1 : rdy2) == 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("rdy_wait", int'(k < 1000), 1);
        drive(which, 1'b1, d);
        @(negedge clk);
        drive(which, 1'b0, 8'($urandom));
        check("first_low", (which == 1) ? tx1 : tx2, 0);
        k        = 0;
        rdy_seen = 1'b0;
        while (((which == 1) ? done1 : done2) == 1'b0 && k < 2000) begin
            rdy_seen |= (which == 1) ? rdy1 : rdy2;
            drive(which, k == inject_at, (k == inject_at) ? 8'h55 : 8'($urandom));
            @(negedge clk);
            k++;
        end
        drive(which, 1'b0, 8'h00);
        check("rdy_low_in_msg", rdy_seen, 0);
        span = k + 1;
    endtask

    task automatic chk_frames(input int which, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input int n);
        logic [7:0] e[4];
        int         got;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < n; i++) begin
            got = -1;
            if (which == 1) begin
                if (dec1.size() > 0) got = int'(dec1.pop_front());
            end else begin
                if (dec2.size() > 0) got = int'(dec2.pop_front());
            end
            check($sformatf("frame%0d_dut%0d", i, which), got, int'(e[i]));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int span;
        int k;
        rst = 1'b0; start1 = 1'b0; start2 = 1'b0; din1 = 8'h00; din2 = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx1", tx1, 1);
        check("reset_rdy1", rdy1, 1);
        check("reset_done1", done1, 0);
        check("reset_tx2", tx2, 1);
        check("reset_rdy2", rdy2, 1);
        rst = 1'b1;
        @(negedge clk);

        // Basic message: 0x3A -> '3' 'A' CR LF spanning 160 cycles inclusive of the done cycle.
        dec1.delete();
        send(1, 8'h3A, -1, span);
        check("span_3A", span, 160);
        chk_frames(1, 8'h33, 8'h41, 8'h0D, 8'h0A, 4);

        // Back to back.
        send(1, 8'h00, -1, span);
        check("span_00", span, 160);
        send(1, 8'hFF, -1, span);
        check("span_FF", span, 160);
        chk_frames(1, 8'h30, 8'h30, 8'h0D, 8'h0A, 4);
        chk_frames(1, 8'h46, 8'h46, 8'h0D, 8'h0A, 4);

        // Second request mid-message is dropped.
        send(1, 8'h12, 50, span);
        check("span_12", span, 160);
        chk_frames(1, 8'h31, 8'h32, 8'h0D, 8'h0A, 4);
        @(negedge clk);
        check("drop_idle_rdy", rdy1, 1);
        @(negedge clk);
        check("drop_idle_tx", tx1, 1);

        // Reset during the data bits of the second character.
        start1 = 1'b1; din1 = 8'h5E;
        @(negedge clk);
        start1 = 1'b0;
        repeat (55) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_tx1", tx1, 1);
        check("async_rdy1", rdy1, 1);
        check("async_done1", done1, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        dec1.delete();
        send(1, 8'h9B, -1, span);
        check("span_9B", span, 160);
        chk_frames(1, 8'h39, 8'h42, 8'h0D, 8'h0A, 4);

        // No CR LF: two frames, 80 cycles.
        dec2.delete();
        send(2, 8'hC7, -1, span);
        check("span_C7", span, 80);
        chk_frames(2, 8'h43, 8'h37, 8'h00, 8'h00, 2);
        @(negedge clk);
        check("crlf0_idle", dec2.size(), 0);

        // Random start/din traffic on both instances, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            start1 = ($urandom_range(0, 7) == 0);
            din1   = 8'($urandom);
            start2 = ($urandom_range(0, 5) == 0);
            din2   = 8'($urandom);
            @(negedge clk);
        end
        start1 = 1'b0;
        start2 = 1'b0;
        k = 0;
        while (!(rdy1 && rdy2) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("final_idle", int'(k < 1000), 1);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
